// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory initiator and its lane aligner:
// size codes, FSM state encoding, default read timeout and alignment check.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Reserved size 2'b11 is handled as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      default: bad = (offset != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte-enables and lane replication,
// load lane selection with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        is_signed_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_word_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Steer store data onto lanes and pull the addressed lane out of a load word.
  always_comb begin
    st_be_o   = 4'b0000;
    st_word_o = 32'h0000_0000;
    ld_data_o = 32'h0000_0000;
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    case (size_i)
      SZ_B: begin
        st_be_o   = 4'b0001 << offset_i;
        st_word_o = {4{st_data_i[7:0]}};
        case (offset_i)
          2'd0:    byte_s = ld_word_i[7:0];
          2'd1:    byte_s = ld_word_i[15:8];
          2'd2:    byte_s = ld_word_i[23:16];
          default: byte_s = ld_word_i[31:24];
        endcase
        ld_data_o = {{24{is_signed_i & byte_s[7]}}, byte_s};
      end
      SZ_H: begin
        st_be_o   = offset_i[1] ? 4'b1100 : 4'b0011;
        st_word_o = {2{st_data_i[15:0]}};
        if (offset_i[1]) begin
          half_s = ld_word_i[31:16];
        end else begin
          half_s = ld_word_i[15:0];
        end
        ld_data_o = {{16{is_signed_i & half_s[15]}}, half_s};
      end
      default: begin
        st_be_o   = 4'b1111;
        st_word_o = st_data_i;
        ld_data_o = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_initiator.sv
// Data-memory initiator: turns MEM-stage load/store requests into word accesses
// on the responder port, waits on its busy/ready handshake and returns the result.
module dmem_initiator
  import mem_pkg::*;
#(
  parameter int AW      = 7,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          misalign,
  output logic          timeout,
  output logic          mem_re,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_dready
);

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          seen_busy_q;
  logic [1:0]    size_q;
  logic [1:0]    offset_q;
  logic          signed_q;
  logic          resp_valid_q;
  logic [31:0]   resp_rdata_q;
  logic          misalign_q;
  logic          timeout_q;
  logic          mem_re_q;
  logic [3:0]    mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic [1:0]    la_size_s;
  logic [1:0]    la_offset_s;
  logic          la_signed_s;
  logic [3:0]    la_be_s;
  logic [31:0]   la_wword_s;
  logic [31:0]   la_rdata_s;
  logic          unused_addr_s;

  assign unused_addr_s = ^req_addr[31:AW+2];

  // In IDLE the aligner sees the live request; during a read it sees the latched one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      la_size_s   = req_size;
      la_offset_s = req_addr[1:0];
      la_signed_s = req_signed;
    end else begin
      la_size_s   = size_q;
      la_offset_s = offset_q;
      la_signed_s = signed_q;
    end
  end

  mem_lane_align u_align (
    .size_i      (la_size_s),
    .offset_i    (la_offset_s),
    .is_signed_i (la_signed_s),
    .st_data_i   (req_wdata),
    .ld_word_i   (mem_rdata),
    .st_be_o     (la_be_s),
    .st_word_o   (la_wword_s),
    .ld_data_o   (la_rdata_s)
  );

  // Pipeline hold: only DONE releases a request that IDLE has seen.
  always_comb begin
    case (state_q)
      ST_IDLE:  stall = req_valid;
      ST_READ:  stall = 1'b1;
      ST_WRITE: stall = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // Access sequencer with registered memory-side and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      seen_busy_q  <= 1'b0;
      size_q       <= 2'b00;
      offset_q     <= 2'b00;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_size, req_addr[1:0])) begin
              misalign_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
              state_q      <= ST_DONE;
            end else if (req_write) begin
              mem_we_q    <= la_be_s;
              mem_addr_q  <= req_addr[AW+1:2];
              mem_wdata_q <= la_wword_s;
              state_q     <= ST_WRITE;
            end else begin
              mem_re_q    <= 1'b1;
              mem_addr_q  <= req_addr[AW+1:2];
              size_q      <= req_size;
              offset_q    <= req_addr[1:0];
              signed_q    <= req_signed;
              cnt_q       <= 4'd0;
              seen_busy_q <= 1'b0;
              state_q     <= ST_READ;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          cnt_q       <= cnt_q + 4'd1;
          seen_busy_q <= seen_busy_q | mem_dready;
          // Busy must have been seen high before a low level counts as ready.
          if (seen_busy_q && !mem_dready) begin
            resp_rdata_q <= la_rdata_s;
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (cnt_q == 4'(TIMEOUT - 1)) begin
            resp_rdata_q <= 32'h0000_0000;
            mem_re_q     <= 1'b0;
            timeout_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_WRITE: begin
          mem_we_q     <= 4'b0000;
          resp_rdata_q <= 32'h0000_0000;
          resp_valid_q <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
          misalign_q   <= 1'b0;
          timeout_q    <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misalign   = misalign_q;
  assign timeout    = timeout_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Directed bench for dmem_initiator: loads, stores, misalignment, timeout and
// mid-read reset, with hand-computed expectations sampled on the falling edge.
module tb_dmem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        timeout;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_dready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_initiator #(.AW(7), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .misalign   (misalign),
    .timeout    (timeout),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_dready (mem_dready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stall"},      32'(stall),      32'd0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, " misalign"},   32'(misalign),   32'd0);
    chk({tag, " timeout"},    32'(timeout),    32'd0);
    chk({tag, " mem_re"},     32'(mem_re),     32'd0);
    chk({tag, " mem_we"},     32'(mem_we),     32'd0);
    chk({tag, " mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, " mem_wdata"},  mem_wdata,       32'd0);
  endtask

  task automatic present(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // Load with busy high for exactly the first READ cycle; response expected in A+3.
  task automatic load_op(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] rd, input logic [31:0] exp);
    int n;
    int got_at;
    n      = 0;
    got_at = 0;
    @(negedge clk);
    present(1'b0, sz, sg, addr, 32'h0);
    mem_rdata  = rd;
    mem_dready = 1'b0;
    while (got_at == 0 && n < 40) begin
      @(negedge clk);
      n++;
      mem_dready = (n == 1);
      #1;
      if (resp_valid) begin
        got_at = n;
        chk({tag, " rdata"},    resp_rdata,    exp);
        chk({tag, " misalign"}, 32'(misalign), 32'd0);
        chk({tag, " stall"},    32'(stall),    32'd0);
      end
    end
    chk({tag, " latency"}, 32'(got_at), 32'd3);
    req_valid  = 1'b0;
    mem_dready = 1'b0;
  endtask

  task automatic store_op(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_we,
                          input logic [6:0] exp_addr, input logic [31:0] exp_wd);
    @(negedge clk);
    present(1'b1, sz, 1'b0, addr, wd);
    #1;
    chk({tag, " accept stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, " we"},       32'(mem_we),     32'(exp_we));
    chk({tag, " addr"},     32'(mem_addr),   32'(exp_addr));
    chk({tag, " wdata"},    mem_wdata,       exp_wd);
    chk({tag, " rv early"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, " we off"},   32'(mem_we),     32'd0);
    chk({tag, " rv"},       32'(resp_valid), 32'd1);
    chk({tag, " rdata0"},   resp_rdata,      32'd0);
    req_valid = 1'b0;
  endtask

  task automatic misalign_op(input string tag, input logic wr, input logic [1:0] sz,
                             input logic [31:0] addr);
    @(negedge clk);
    present(wr, sz, 1'b0, addr, 32'hFFFF_FFFF);
    mem_rdata = 32'h5555_5555;
    #1;
    chk({tag, " stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    chk({tag, " rv"},       32'(resp_valid), 32'd1);
    chk({tag, " misalign"}, 32'(misalign),   32'd1);
    chk({tag, " rdata"},    resp_rdata,      32'd0);
    chk({tag, " re"},       32'(mem_re),     32'd0);
    chk({tag, " we"},       32'(mem_we),     32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " rv drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_at;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_rdata  = 32'h0;
    mem_dready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b1;

    // LW 0x10: busy high in A+2 and A+3, low in A+4.
    @(negedge clk);
    present(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw A stall", 32'(stall), 32'd1);
    chk("lw A re",    32'(mem_re), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      mem_dready = (k == 2 || k == 3);
      if (k == 6) req_valid = 1'b0;
      #1;
      chk($sformatf("lw A+%0d re", k),    32'(mem_re),     32'(k <= 4));
      chk($sformatf("lw A+%0d stall", k), 32'(stall),      32'(k <= 4));
      chk($sformatf("lw A+%0d rv", k),    32'(resp_valid), 32'(k == 5));
      if (k == 1) chk("lw addr", 32'(mem_addr), 32'd4);
      if (k == 5) chk("lw rdata", resp_rdata, 32'hDEAD_BEEF);
    end
    mem_dready = 1'b0;

    load_op("lb s 13",  2'b00, 1'b1, 32'h13, 32'h80FF_0000, 32'hFFFF_FF80);
    load_op("lbu 13",   2'b00, 1'b0, 32'h13, 32'h80FF_0000, 32'h0000_0080);
    load_op("lb s 12",  2'b00, 1'b1, 32'h12, 32'h80FF_0000, 32'hFFFF_FFFF);
    load_op("lb s 11",  2'b00, 1'b1, 32'h11, 32'h80FF_0000, 32'h0000_0000);
    load_op("lh s 12",  2'b01, 1'b1, 32'h12, 32'h80FF_0000, 32'hFFFF_80FF);
    load_op("lhu 12",   2'b01, 1'b0, 32'h12, 32'h80FF_0000, 32'h0000_80FF);
    load_op("lh s 10",  2'b01, 1'b1, 32'h10, 32'h1234_8001, 32'hFFFF_8001);
    load_op("lw s",     2'b10, 1'b1, 32'h20, 32'h8000_0001, 32'h8000_0001);
    load_op("lw rsv",   2'b11, 1'b0, 32'h24, 32'h1234_5678, 32'h1234_5678);

    store_op("sh 06", 2'b01, 32'h06,        32'h1234_ABCD, 4'b1100, 7'd1,    32'hABCD_ABCD);
    store_op("sb 103",2'b00, 32'h103,       32'hFFFF_FF77, 4'b1000, 7'h40,   32'h7777_7777);
    store_op("sw hi", 2'b10, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'b1111, 7'h7F,   32'hCAFE_F00D);
    store_op("sh 00", 2'b01, 32'h00,        32'h0000_BEEF, 4'b0011, 7'd0,    32'hBEEF_BEEF);

    misalign_op("mis lw 02", 1'b0, 2'b10, 32'h02);
    misalign_op("mis sh 05", 1'b1, 2'b01, 32'h05);
    misalign_op("mis sw 03", 1'b1, 2'b10, 32'h03);

    // Timeout: busy never seen; expect 15 READ cycles then DONE.
    @(negedge clk);
    present(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    mem_rdata  = 32'hAAAA_AAAA;
    mem_dready = 1'b0;
    done_at    = 0;
    for (int n = 1; n <= 30 && done_at == 0; n++) begin
      @(negedge clk);
      #1;
      if (n == 15) chk("to re c15", 32'(mem_re), 32'd1);
      if (resp_valid) begin
        done_at = n;
        chk("to flag",  32'(timeout),  32'd1);
        chk("to rdata", resp_rdata,    32'd0);
        chk("to re",    32'(mem_re),   32'd0);
        chk("to mis",   32'(misalign), 32'd0);
      end
    end
    chk("to cycle", 32'(done_at), 32'd16);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("to clear", 32'(timeout), 32'd0);

    // Reset during READ cycle A+3.
    @(negedge clk);
    present(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    mem_rdata = 32'h1111_2222;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      mem_dready = (k >= 2);
    end
    #1;
    chk("rst pre re", 32'(mem_re), 32'd1);
    rst        = 1'b0;
    req_valid  = 1'b0;
    mem_dready = 1'b0;
    @(negedge clk);
    #1;
    chk_idle_outputs("mid rst");
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post rst rv %0d", k), 32'(resp_valid), 32'd0);
    end
    store_op("sb 01", 2'b00, 32'h01, 32'h0000_005A, 4'b0010, 7'd0, 32'h5A5A_5A5A);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
